// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream with an end-of-transfer marker, as produced by
// ram_stream_reader.
interface ram_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Streams `count` words starting at `base` from the RAM B port onto a
// valid/ready interface, hiding the RAM's one-cycle registered read latency.
module ram_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          base,
  input  logic [31:0]          count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [31:0]          ram_length,
  output logic [31:0]          ram_address,
  output logic [WIDTH-1:0]     ram_din,
  output logic                 ram_we,
  output logic                 ram_oe,
  input  logic [WIDTH-1:0]     ram_dout,
  ram_stream_reader_if.master  strm
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [31:0]      base_q;
  logic [31:0]      count_q;
  logic [31:0]      issued;
  logic             err_flag;
  logic             oe_last;
  logic             cap_valid;
  logic             cap_last;
  logic [AW:0]      occ;
  logic [AW:0]      credit;
  logic [AW:0]      credit_after;
  logic [AW:0]      pop_ext;
  logic [AW:0]      push_ext;
  logic [AW:0]      issue_ext;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic             fifo_last [FIFO_DEPTH];
  logic             pop;
  logic             issue;
  logic [32:0]      req_end;

  assign ram_din = '0;
  assign ram_we  = 1'b0;

  assign strm.out_valid = (occ != '0);
  assign strm.out_data  = fifo_data[rptr];
  assign strm.out_last  = strm.out_valid & fifo_last[rptr];

  assign pop     = strm.out_valid & strm.out_ready;
  assign req_end = {1'b0, base} + {1'b0, count};

  // credit = words in the FIFO plus reads still travelling through the RAM;
  // bounding it by the depth guarantees every issued read has a slot.
  always_comb begin
    pop_ext      = '0;
    pop_ext[0]   = pop;
    push_ext     = '0;
    push_ext[0]  = cap_valid;
    credit_after = credit - pop_ext;
    issue        = (state == RUN) && (issued < count_q) && (credit_after < DEPTH_W);
    issue_ext    = '0;
    issue_ext[0] = issue;
  end

  // Empty and out-of-range requests pass through RUN with nothing to issue,
  // which gives them the same one-cycle settle before the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued      <= '0;
      err_flag    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ram_oe      <= 1'b0;
      ram_address <= '0;
      oe_last     <= 1'b0;
      cap_valid   <= 1'b0;
      cap_last    <= 1'b0;
      credit      <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      ram_oe    <= 1'b0;
      oe_last   <= 1'b0;
      cap_valid <= ram_oe;
      cap_last  <= oe_last;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            base_q   <= base;
            issued   <= '0;
            err_flag <= 1'b0;
            credit   <= '0;
            if (count == '0) begin
              count_q <= '0;
            end else if (req_end > {1'b0, ram_length}) begin
              count_q  <= '0;
              err_flag <= 1'b1;
            end else begin
              count_q     <= count;
              ram_oe      <= 1'b1;
              ram_address <= base;
              issued      <= 32'd1;
              oe_last     <= (count == 32'd1);
              credit      <= (AW+1)'(1);
            end
          end
        end
        RUN: begin
          credit <= credit_after + issue_ext;
          if (issue) begin
            ram_oe      <= 1'b1;
            ram_address <= base_q + issued;
            issued      <= issued + 32'd1;
            oe_last     <= (issued == count_q - 32'd1);
          end
          if ((issued == count_q) && (credit_after == '0)) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= err_flag;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (cap_valid) begin
        fifo_data[wptr] <= ram_dout;
        fifo_last[wptr] <= cap_last;
        wptr            <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      occ <= occ + push_ext - pop_ext;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader driving a behavioural RAM whose
// word at address a reads back as a+100.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] count = '0;
  logic [31:0] ram_length = 32'd1024;
  logic [31:0] ram_address;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
  logic        busy, done, err, ram_we, ram_oe;

  ram_stream_reader_if #(.WIDTH(32)) strm ();

  ram_stream_reader #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .err(err), .ram_length(ram_length),
    .ram_address(ram_address), .ram_din(ram_din), .ram_we(ram_we),
    .ram_oe(ram_oe), .ram_dout(ram_dout), .strm(strm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_oe) ram_dout <= ram_address + 32'd100;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc_rel, oe_cnt, pop_cnt, first_oe, first_valid, done_seen, done_at, max_out;
  logic        err_at_done, busy_at_done, busy_t1, held;
  logic [32:0] held_word;
  logic [3:0]  pat = 4'b1111;
  logic [1:0]  pidx = '0;
  logic [32:0] exp_q [$];

  task automatic clear_mon();
    cyc_rel = 0; oe_cnt = 0; pop_cnt = 0; first_oe = 0; first_valid = 0;
    done_seen = 0; done_at = 0; max_out = 0; held = 1'b0;
    err_at_done = 1'b0; busy_at_done = 1'b0; busy_t1 = 1'b0;
  endtask

  // One clock: observe at the falling edge, then update out_ready after the rising edge.
  task automatic step();
    logic [32:0] e, got;
    @(negedge clk);
    cyc_rel++;
    got = {strm.out_last, strm.out_data};
    if (ram_oe) begin
      oe_cnt++;
      if (first_oe == 0) first_oe = cyc_rel;
    end
    if (oe_cnt - pop_cnt > max_out) max_out = oe_cnt - pop_cnt;
    if (held) begin
      vectors++;
      if (!strm.out_valid || got !== held_word) begin
        miscompares++;
        $display("FAIL hold_stable: got valid=%0b word=%h, required valid=1 word=%h",
                 strm.out_valid, got, held_word);
      end
    end
    if (strm.out_valid) begin
      if (first_valid == 0) first_valid = cyc_rel;
      if (strm.out_ready) begin
        vectors++;
        pop_cnt++;
        held = 1'b0;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got %h, required no word", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL stream_word: got last/data %h, required %h", got, e);
          end
        end
      end else begin
        held = 1'b1;
        held_word = got;
      end
    end else begin
      held = 1'b0;
    end
    if (done) begin
      done_seen++;
      done_at = cyc_rel;
      err_at_done = err;
      busy_at_done = busy;
    end
    if (cyc_rel == 1) busy_t1 = busy;
    @(posedge clk); #1;
    pidx = pidx + 2'd1;
    strm.out_ready = pat[pidx];
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [31:0] c, input logic expect_words);
    clear_mon();
    base = b; count = c; start = 1'b1;
    if (expect_words)
      for (int unsigned i = 0; i < c; i++) exp_q.push_back({(i == c - 1), b + i + 32'd100});
    pidx = '0;
    strm.out_ready = pat[0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_seen == 0 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (done_seen == 0) begin
      miscompares++;
      $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", budget);
    end
  endtask

  task automatic finish_xfer(input int budget);
    wait_done(budget);
    step(); step();
    vectors++;
    if (done_seen != 1 || busy !== 1'b0 || busy_at_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_pulse: got done count=%0d busy_at_done=%0b busy_after=%0b, required 1/1/0",
               done_seen, busy_at_done, busy);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL words_left: got %0d undelivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({busy, done, err, ram_oe, ram_we, strm.out_valid, strm.out_last} !== 7'b0 ||
        ram_address !== 32'd0 || strm.out_data !== 32'd0 || ram_din !== 32'd0) begin
      miscompares++;
      $display("FAIL %s: got busy=%0b done=%0b err=%0b oe=%0b we=%0b valid=%0b last=%0b addr=%h data=%h, required all 0",
               name, busy, done, err, ram_oe, ram_we, strm.out_valid, strm.out_last, ram_address, strm.out_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    pat = 4'b1111;
    start_xfer(32'd0, 32'd8, 1'b1);
    finish_xfer(40);
    vectors++;
    if (first_oe != 1 || first_valid != 3 || busy_t1 !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: got oe@%0d valid@%0d busy_t1=%0b, required oe@1 valid@3 busy_t1=1",
               first_oe, first_valid, busy_t1);
    end
    vectors++;
    if (done_at != 11 || err_at_done !== 1'b0 || oe_cnt != 8) begin
      miscompares++;
      $display("FAIL basic_done: got done@%0d err=%0b oe=%0d, required done@11 err=0 oe=8",
               done_at, err_at_done, oe_cnt);
    end
  endtask

  task automatic test_backpressure();
    pat = 4'b1001;
    start_xfer(32'd0, 32'd8, 1'b1);
    finish_xfer(100);
    vectors++;
    if (oe_cnt != 8 || max_out > 4 || err_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure: got oe=%0d max_outstanding=%0d err=%0b, required oe=8 max<=4 err=0",
               oe_cnt, max_out, err_at_done);
    end
  endtask

  task automatic test_stall();
    pat = 4'b0000;
    start_xfer(32'd0, 32'd16, 1'b1);
    repeat (20) step();
    vectors++;
    if (oe_cnt != 4 || pop_cnt != 0) begin
      miscompares++;
      $display("FAIL stall_issue: got oe=%0d pops=%0d, required oe=4 pops=0", oe_cnt, pop_cnt);
    end
    pat = 4'b1111;
    strm.out_ready = 1'b1;
    finish_xfer(80);
    vectors++;
    if (oe_cnt != 16 || pop_cnt != 16) begin
      miscompares++;
      $display("FAIL stall_drain: got oe=%0d pops=%0d, required 16/16", oe_cnt, pop_cnt);
    end
  endtask

  task automatic test_zero_count();
    pat = 4'b1111;
    start_xfer(32'd0, 32'd0, 1'b0);
    finish_xfer(10);
    vectors++;
    if (done_at != 2 || err_at_done !== 1'b0 || oe_cnt != 0 || first_valid != 0) begin
      miscompares++;
      $display("FAIL zero_count: got done@%0d err=%0b oe=%0d valid@%0d, required done@2 err=0 oe=0 valid never",
               done_at, err_at_done, oe_cnt, first_valid);
    end
  endtask

  task automatic test_range();
    pat = 4'b1111;
    ram_length = 32'd1024;
    start_xfer(32'd1020, 32'd8, 1'b0);
    finish_xfer(10);
    vectors++;
    if (done_at != 2 || err_at_done !== 1'b1 || oe_cnt != 0 || first_valid != 0) begin
      miscompares++;
      $display("FAIL range_err: got done@%0d err=%0b oe=%0d valid@%0d, required done@2 err=1 oe=0 valid never",
               done_at, err_at_done, oe_cnt, first_valid);
    end
    start_xfer(32'd1016, 32'd8, 1'b1);
    finish_xfer(40);
    vectors++;
    if (err_at_done !== 1'b0 || oe_cnt != 8 || done_at != 11) begin
      miscompares++;
      $display("FAIL range_edge: got err=%0b oe=%0d done@%0d, required err=0 oe=8 done@11",
               err_at_done, oe_cnt, done_at);
    end
  endtask

  task automatic test_back_to_back();
    pat = 4'b1111;
    start_xfer(32'd32, 32'd3, 1'b1);
    wait_done(30);
    start_xfer(32'd40, 32'd2, 1'b1);
    finish_xfer(30);
    vectors++;
    if (first_oe != 1 || done_at != 5) begin
      miscompares++;
      $display("FAIL back_to_back: got oe@%0d done@%0d, required oe@1 done@5", first_oe, done_at);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    pat = 4'b1111;
    start_xfer(32'd0, 32'd8, 1'b1);
    while (pop_cnt < 3 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (pop_cnt != 3) begin
      miscompares++;
      $display("FAIL mid_progress: got %0d words, required 3", pop_cnt);
    end
    reset = 1'b0;
    #2;
    check_idle_outputs("mid_reset_outputs");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("held_in_reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    start_xfer(32'd4, 32'd2, 1'b1);
    finish_xfer(30);
    vectors++;
    if (oe_cnt != 2 || pop_cnt != 2 || done_at != 5 || err_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: got oe=%0d pops=%0d done@%0d err=%0b, required 2/2/5/0",
               oe_cnt, pop_cnt, done_at, err_at_done);
    end
  endtask

  initial begin
    strm.out_ready = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_zero_count();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
